// File: rtl/rcswitch_send.sv
// rc-switch telegram serializer: latches a 128-bit pre-encoded waveform on send
// and shifts it out MSB-first, each bit held BIT_TICKS cycles, REPEAT times.
module rcswitch_send #(
  parameter int BIT_TICKS = 1,
  parameter int REPEAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [39:0] addr,
  input  logic [39:0] chan,
  input  logic [15:0] stat,
  input  logic [31:0] sync,
  output logic        ready,
  output logic        out,
  output logic        o_dbg_state
);

  localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int REP_W  = (REPEAT > 1) ? $clog2(REPEAT + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TX   = 1'b1
  } state_t;

  state_t              r_state, w_next_state;
  logic [127:0]        r_frame, w_frame_nxt;
  logic [6:0]          r_idx, w_idx_nxt;
  logic [TICK_W-1:0]   r_tick, w_tick_nxt;
  logic [REP_W-1:0]    r_rep, w_rep_nxt;
  logic                r_out, w_out_nxt;
  logic                r_ready, w_ready_nxt;
  logic [127:0]        w_frame_in;

  assign w_frame_in  = {addr, chan, stat, sync};
  assign ready       = r_ready;
  assign out         = r_out;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_idx   <= '0;
      r_tick  <= '0;
      r_rep   <= '0;
      r_out   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_frame <= w_frame_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
      r_rep   <= w_rep_nxt;
      r_out   <= w_out_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Handshake: a frame is accepted on any rising edge where send=1 and ready=1;
  // send is a level, so holding it high chains frames with one idle cycle between.
  // out/ready are computed one edge ahead so both leave the block registered.
  always_comb begin
    w_next_state = r_state;
    w_frame_nxt  = r_frame;
    w_idx_nxt    = r_idx;
    w_tick_nxt   = r_tick;
    w_rep_nxt    = r_rep;
    w_out_nxt    = 1'b0;
    w_ready_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_frame_nxt  = w_frame_in;
          w_idx_nxt    = 7'd127;
          w_tick_nxt   = '0;
          w_rep_nxt    = '0;
          w_out_nxt    = w_frame_in[127];
          w_ready_nxt  = 1'b0;
          w_next_state = S_TX;
        end
      end
      S_TX: begin
        w_ready_nxt = 1'b0;
        w_out_nxt   = r_frame[r_idx];
        if (r_tick == TICK_LAST) begin
          w_tick_nxt = '0;
          if (r_idx == 7'd0) begin
            if (r_rep == REP_LAST) begin
              w_next_state = S_IDLE;
              w_rep_nxt    = '0;
              w_out_nxt    = 1'b0;
              w_ready_nxt  = 1'b1;
            end else begin
              w_rep_nxt = r_rep + 1'b1;
              w_idx_nxt = 7'd127;
              w_out_nxt = r_frame[127];
            end
          end else begin
            w_idx_nxt = r_idx - 7'd1;
            w_out_nxt = r_frame[r_idx - 7'd1];
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rcswitch_send.sv
// Self-checking bench for rcswitch_send: default instance plus a BIT_TICKS=4,
// REPEAT=2 instance, checked against an expected-bit queue.
module tb_rcswitch_send;

  logic        clk;
  logic        rst;
  logic        send0, send4;
  logic [39:0] addr, chan;
  logic [15:0] stat;
  logic [31:0] sync;
  logic        ready0, out0, dbg0;
  logic        ready4, out4, dbg4;

  logic [0:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  rcswitch_send dut (
    .clk(clk), .rst(rst), .send(send0),
    .addr(addr), .chan(chan), .stat(stat), .sync(sync),
    .ready(ready0), .out(out0), .o_dbg_state(dbg0)
  );

  rcswitch_send #(.BIT_TICKS(4), .REPEAT(2)) dut4 (
    .clk(clk), .rst(rst), .send(send4),
    .addr(addr), .chan(chan), .stat(stat), .sync(sync),
    .ready(ready4), .out(out4), .o_dbg_state(dbg4)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [127:0] f, input int ticks, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 127; i >= 0; i--)
        for (int t = 0; t < ticks; t++)
          exp_q.push_back(f[i]);
  endtask

  task automatic set_data(input logic [39:0] a, input logic [39:0] c,
                          input logic [15:0] s, input logic [31:0] y);
    addr = a; chan = c; stat = s; sync = y;
  endtask

  // Pops one expected bit per cycle while the selected DUT is transmitting.
  task automatic drain(input int sel, input int drop_at, input int corrupt_at, input int rst_at);
    int   k;
    logic e, o, r;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      o = (sel != 0) ? out4 : out0;
      r = (sel != 0) ? ready4 : ready0;
      e = exp_q.pop_front();
      check("tx_ready", {31'd0, r}, 32'd0);
      check("tx_out", {31'd0, o}, {31'd0, e});
      if (k == drop_at) begin
        send0 = 1'b0;
        send4 = 1'b0;
      end
      if (k == corrupt_at) set_data('1, '1, '1, '1);
      if (k == rst_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, ready0}, 32'd1);
        check("rst_mid_out", {31'd0, out0}, 32'd0);
        exp_q.delete();
        return;
      end
    end
    @(negedge clk);
    o = (sel != 0) ? out4 : out0;
    r = (sel != 0) ? ready4 : ready0;
    check("idle_ready", {31'd0, r}, 32'd1);
    check("idle_out", {31'd0, o}, 32'd0);
  endtask

  logic [127:0] f_a, f_b;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    send0 = 1'b0;
    send4 = 1'b0;
    set_data('0, '0, '0, '0);

    // reset seen before any clock edge, then held 10 cycles
    #1;
    check("rst_ready0", {31'd0, ready0}, 32'd1);
    check("rst_out0", {31'd0, out0}, 32'd0);
    check("rst_ready4", {31'd0, ready4}, 32'd1);
    check("rst_out4", {31'd0, out4}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst_hold_ready", {31'd0, ready0}, 32'd1);
      check("rst_hold_out", {31'd0, out0}, 32'd0);
      check("rst_hold_state", {31'd0, dbg0}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // single frame, send held 50 cycles
    set_data(40'h8888888888, 40'h888E8E8E8E, 16'h8E88, 32'h80000000);
    f_a = {40'h8888888888, 40'h888E8E8E8E, 16'h8E88, 32'h80000000};
    send0 = 1'b1;
    push_frame(f_a, 1, 1);
    drain(0, 50, -1, -1);

    // send held high: two identical frames with one idle cycle between
    send0 = 1'b1;
    push_frame(f_a, 1, 1);
    drain(0, -1, -1, -1);
    push_frame(f_a, 1, 1);
    drain(0, 5, -1, -1);

    // inputs changed mid-frame do not affect the latched frame
    f_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    set_data(f_b[127:88], f_b[87:48], f_b[47:32], f_b[31:0]);
    send0 = 1'b1;
    push_frame(f_b, 1, 1);
    drain(0, 3, 10, -1);

    // reset at cycle 60 abandons the frame; a fresh one starts from bit 127
    set_data(f_a[127:88], f_a[87:48], f_a[47:32], f_a[31:0]);
    send0 = 1'b1;
    push_frame(f_a, 1, 1);
    drain(0, 20, -1, 60);
    @(negedge clk);
    check("rst_hold2_ready", {31'd0, ready0}, 32'd1);
    check("rst_hold2_out", {31'd0, out0}, 32'd0);
    rst = 1'b0;
    repeat ($urandom_range(3, 1)) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, ready0}, 32'd1);
      check("post_rst_out", {31'd0, out0}, 32'd0);
    end
    f_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    set_data(f_b[127:88], f_b[87:48], f_b[47:32], f_b[31:0]);
    send0 = 1'b1;
    push_frame(f_b, 1, 1);
    drain(0, 1, -1, -1);

    // stretched, repeated instance: 4 cycles per bit, two repetitions
    set_data(f_a[127:88], f_a[87:48], f_a[47:32], f_a[31:0]);
    send4 = 1'b1;
    push_frame(f_a, 4, 2);
    check("q_len4", exp_q.size(), 32'd1024);
    drain(1, 2, -1, -1);
    check("idle_state4", {31'd0, dbg4}, 32'd0);
    check("default_idle", {31'd0, ready0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
